// File: rtl/mac_tx_framer.sv
// Store-and-forward byte-to-dibit framer feeding the RMII MAC; a whole frame is buffered, then streamed LSB-dibit first with no gaps.
// Holds the current dibit while axi_ready is low; MAC_TX_PAD_EN zero-pads short frames up to MIN_FRAME_BYTES.
module mac_tx_framer #(
  parameter int DEPTH           = 2048,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        axi_valid,
  output logic [1:0]  axi_din,
  input  logic        axi_ready,
  output logic        drop_pulse,
  output logic [15:0] frame_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_FRAME_BYTES);
`ifdef MAC_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_LOAD, ST_DROP, ST_PREP, ST_SEND} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   byte_idx_q, byte_idx_d;
  logic [1:0]      dib_idx_q, dib_idx_d;
  logic [7:0]      cur_byte_q, cur_byte_d;
  logic            prep_rd_q, prep_rd_d;
  logic            in_ready_q, in_ready_d;
  logic            drop_pulse_q, drop_pulse_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_rd_q;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;

  logic            accept;
  logic            fire;
  logic            last_dibit;
  logic [CW-1:0]   send_len;
  logic [CW-1:0]   next_idx;

  assign accept     = in_valid && in_ready_q;
  assign fire       = axi_ready && (state_q == ST_SEND);
  assign send_len   = (PAD_EN && (len_q < MIN_C)) ? MIN_C : len_q;
  assign next_idx   = byte_idx_q + CW'(1);
  assign last_dibit = (next_idx == send_len) && (dib_idx_q == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (in_last)                state_d = ST_PREP;
          else if (count_q == LAST_C) state_d = ST_DROP;
        end
      end
      ST_DROP: if (accept && in_last) state_d = ST_LOAD;
      ST_PREP: if (prep_rd_q)         state_d = ST_SEND;
      ST_SEND: if (fire && last_dibit) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // Datapath next values
  always_comb begin
    count_d      = count_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    dib_idx_d    = dib_idx_q;
    cur_byte_d   = cur_byte_q;
    prep_rd_d    = 1'b0;
    drop_pulse_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    wr_en        = 1'b0;
    wr_addr      = AW'(count_q);
    rd_addr      = AW'(next_idx);
    case (state_q)
      ST_LOAD: begin
        byte_idx_d = '0;
        if (accept) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          if (in_last) len_d = count_q + CW'(1);
        end
      end
      ST_DROP: begin
        byte_idx_d = '0;
        if (accept && in_last) begin
          drop_pulse_d = 1'b1;
          count_d      = '0;
        end
      end
      ST_PREP: begin
        // Two-step prep: fetch byte 0, then load it while fetching byte 1.
        rd_addr   = prep_rd_q ? AW'(1) : '0;
        prep_rd_d = !prep_rd_q;
        if (prep_rd_q) begin
          cur_byte_d = mem_rd_q;
          dib_idx_d  = 2'd0;
          byte_idx_d = '0;
        end
      end
      ST_SEND: begin
        if (fire) begin
          if (last_dibit) begin
            count_d     = '0;
            dib_idx_d   = 2'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else if (dib_idx_q == 2'd3) begin
            // mem_rd_q already holds the prefetched next byte.
            dib_idx_d  = 2'd0;
            byte_idx_d = next_idx;
            cur_byte_d = (PAD_EN && (next_idx >= len_q)) ? 8'h00 : mem_rd_q;
          end else begin
            dib_idx_d = dib_idx_q + 2'd1;
          end
        end
      end
      default: ;
    endcase
    in_ready_d = (state_d == ST_LOAD) || (state_d == ST_DROP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      dib_idx_q    <= 2'd0;
      cur_byte_q   <= 8'h00;
      prep_rd_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      drop_pulse_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      count_q      <= count_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      dib_idx_q    <= dib_idx_d;
      cur_byte_q   <= cur_byte_d;
      prep_rd_q    <= prep_rd_d;
      in_ready_q   <= in_ready_d;
      drop_pulse_q <= drop_pulse_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Frame buffer: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= in_data;
    mem_rd_q <= mem_q[rd_addr];
  end

  // Outputs
  always_comb begin
    axi_valid = (state_q == ST_SEND);
    axi_din   = 2'b00;
    if (state_q == ST_SEND) axi_din = cur_byte_q[{dib_idx_q, 1'b0} +: 2];
  end

  assign in_ready   = in_ready_q;
  assign drop_pulse = drop_pulse_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: expected dibits are queued as frames are driven and checked as the MAC consumes them.
module tb_mac_tx_framer;

  localparam int MIN_BYTES = 60;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        axi_valid;
  logic [1:0]  axi_din;
  logic        axi_ready;
  logic        drop_pulse;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [1:0] d;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frame_buf [4096];
  int         checks = 0;
  int         errors = 0;
  int         drop_cnt = 0;
  int         dib_in_frame = 0;
  int         last_frame_dibits = 0;
  bit         mid_frame = 0;
  bit         expect_low = 0;
  bit         rnd_mode = 0;

  mac_tx_framer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .axi_valid  (axi_valid),
    .axi_din    (axi_din),
    .axi_ready  (axi_ready),
    .drop_pulse (drop_pulse),
    .frame_cnt  (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MAC model: ready low for 32 cycles after valid rises, then steady or random
  initial begin
    int pre;
    pre = 0;
    axi_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!axi_valid) begin
        pre = 0;
        axi_ready = 1'b0;
      end else if (pre < 32) begin
        pre++;
        axi_ready = 1'b0;
      end else begin
        axi_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Output monitor and scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        mid_frame = 0;
        expect_low = 0;
        dib_in_frame = 0;
      end else begin
        if (drop_pulse) drop_cnt++;
        if (expect_low) begin
          checks++;
          if (axi_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_fall: axi_valid=%b after last dibit, expected 0", axi_valid);
          end
          expect_low = 0;
        end
        if (axi_valid) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_send: in_ready=%b, expected 0", in_ready);
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid: axi_valid=1 din=%b with nothing expected", axi_din);
          end else if (axi_ready) begin
            e = exp_q.pop_front();
            checks++;
            if (axi_din !== e.d) begin
              errors++;
              $display("FAIL dibit[%0d]: got %b expected %b", dib_in_frame, axi_din, e.d);
            end
            dib_in_frame++;
            mid_frame = !e.last;
            if (e.last) begin
              expect_low = 1;
              last_frame_dibits = dib_in_frame;
              dib_in_frame = 0;
            end
          end else begin
            mid_frame = 1;
            checks++;
            if (axi_din !== exp_q[0].d) begin
              errors++;
              $display("FAIL hold[%0d]: got %b expected %b", dib_in_frame, axi_din, exp_q[0].d);
            end
          end
        end else if (mid_frame) begin
          checks++;
          errors++;
          $display("FAIL valid_drop: axi_valid=0 mid-frame at dibit %0d, expected 1", dib_in_frame);
          mid_frame = 0;
        end
      end
    end
  end

  task automatic fill(input int len, input int base, input int step);
    for (int i = 0; i < len; i++) frame_buf[i] = 8'(base + i * step);
  endtask

  task automatic push_expected(input int len);
    int total;
    logic [7:0] b;
    total = len;
`ifdef MAC_TX_PAD_EN
    if (total < MIN_BYTES) total = MIN_BYTES;
`endif
    for (int i = 0; i < total; i++) begin
      b = (i < len) ? frame_buf[i] : 8'h00;
      for (int k = 0; k < 4; k++)
        exp_q.push_back('{d: b[2*k +: 2], last: (i == total - 1) && (k == 3)});
    end
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) begin
      bit ok;
      in_valid = 1'b1;
      in_data  = frame_buf[i];
      in_last  = (i == len - 1);
      ok = 0;
      for (int w = 0; w < 5000 && !ok; w++) begin
        @(negedge clk);
        if (in_ready) ok = 1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL send_timeout: byte %0d in_ready=%b, expected 1", i, in_ready);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int w = 0; w < 6000 && !done; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !axi_valid) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: %0d dibits outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input int exp_cnt);
    checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    if (axi_valid !== 1'b0)  begin errors++; $display("FAIL rst_axi_valid: got %b expected 0", axi_valid); end
    if (axi_din !== 2'b00)   begin errors++; $display("FAIL rst_axi_din: got %b expected 00", axi_din); end
    if (drop_pulse !== 1'b0) begin errors++; $display("FAIL rst_drop_pulse: got %b expected 0", drop_pulse); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_byte();
    rnd_mode = 0;
    frame_buf[0] = 8'hE4;
    push_expected(1);
    send_frame(1);
    wait_idle();
    check_cnt(1);
    checks++;
`ifdef MAC_TX_PAD_EN
    if (last_frame_dibits != 4 * MIN_BYTES) begin
      errors++; $display("FAIL single_len: got %0d dibits expected %0d", last_frame_dibits, 4 * MIN_BYTES);
    end
`else
    if (last_frame_dibits != 4) begin
      errors++; $display("FAIL single_len: got %0d dibits expected 4", last_frame_dibits);
    end
`endif
  endtask

  task automatic test_random_ready();
    rnd_mode = 1;
    fill(64, 0, 1);
    push_expected(64);
    send_frame(64);
    wait_idle();
    rnd_mode = 0;
    check_cnt(2);
    checks++;
    if (last_frame_dibits != 256) begin
      errors++; $display("FAIL rand64_len: got %0d dibits expected 256", last_frame_dibits);
    end
  endtask

  task automatic test_oversize_drop();
    int d0;
    d0 = drop_cnt;
    for (int i = 0; i < 3000; i++) frame_buf[i] = 8'($urandom);
    send_frame(3000);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++; $display("FAIL drop_pulses: got %0d expected 1", drop_cnt - d0);
    end
    check_cnt(2);
    fill(10, 'h70, 5);
    push_expected(10);
    send_frame(10);
    wait_idle();
    check_cnt(3);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++; $display("FAIL drop_pulses_after: got %0d expected 1", drop_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    fill(20, 'hA0, 3);
    push_expected(20);
    send_frame(20);
    fill(30, 'h11, 7);
    push_expected(30);
    send_frame(30);
    wait_idle();
    check_cnt(5);
  endtask

  task automatic test_pad();
    fill(10, 'h5A, 17);
    push_expected(10);
    send_frame(10);
    wait_idle();
    check_cnt(6);
    checks++;
`ifdef MAC_TX_PAD_EN
    if (last_frame_dibits != 240) begin
      errors++; $display("FAIL pad_len: got %0d dibits expected 240", last_frame_dibits);
    end
`else
    if (last_frame_dibits != 40) begin
      errors++; $display("FAIL pad_len: got %0d dibits expected 40", last_frame_dibits);
    end
`endif
  endtask

  task automatic test_mid_frame_reset();
    bit hit;
    rnd_mode = 0;
    fill(100, 5, 1);
    push_expected(100);
    send_frame(100);
    hit = 0;
    for (int w = 0; w < 3000 && !hit; w++) begin
      @(posedge clk);
      #2;
      if (dib_in_frame == 40) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reach_dibit40: at dibit %0d, expected 40", dib_in_frame);
    end
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks += 3;
    if (axi_valid !== 1'b0)  begin errors++; $display("FAIL mrst_axi_valid: got %b expected 0", axi_valid); end
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL mrst_in_ready: got %b expected 0", in_ready); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mrst_frame_cnt: got %0d expected 0", frame_cnt); end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready_after: got %b expected 1", in_ready); end
    fill(8, 'hC3, 13);
    push_expected(8);
    send_frame(8);
    wait_idle();
    check_cnt(1);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_random_ready();
    test_oversize_drop();
    test_back_to_back();
    test_pad();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
